// File: rtl/sync_fifo.sv
// sync_fifo: single-clock parametrised FIFO with registered occupancy,
// threshold flags, overflow/underflow pulses and optional show-ahead read.
module sync_fifo #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_BITS    = 10,
   parameter int ALMOST_FULL  = 768,
   parameter int ALMOST_EMPTY = 16,
   parameter int SHOW_AHEAD   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  wrreq,
   input  logic                  rdreq,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_BITS:0]    usedw,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] LP_DEPTH = (ADDR_BITS + 1)'(DEPTH);
   localparam logic [ADDR_BITS:0] LP_AF = (ADDR_BITS + 1)'(ALMOST_FULL);
   localparam logic [ADDR_BITS:0] LP_AE = (ADDR_BITS + 1)'(ALMOST_EMPTY);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_BITS-1:0]  r_wrptr;
   logic [ADDR_BITS-1:0]  r_rdptr;
   logic [ADDR_BITS:0]    r_usedw;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_afull;
   logic                  r_aempty;
   logic                  r_ovf;
   logic                  r_udf;

   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic [ADDR_BITS:0]    w_usedw_nxt;

   // Flags gate acceptance, so a full FIFO can still be read and
   // an empty one can still be written in the same cycle.
   assign w_wr_ok = en & wrreq & ~r_full;
   assign w_rd_ok = en & rdreq & ~r_empty;

   // Next occupancy: only a lone accepted request moves the count
   always_comb begin
      w_usedw_nxt = r_usedw;
      if (w_wr_ok && !w_rd_ok) begin
         w_usedw_nxt = r_usedw + 1'b1;
      end else if (!w_wr_ok && w_rd_ok) begin
         w_usedw_nxt = r_usedw - 1'b1;
      end
   end

   // Storage array; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (!rst && w_wr_ok) begin
         r_mem[r_wrptr] <= data_in;
      end
   end

   // Pointers, occupancy and all flags move together on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrptr  <= '0;
         r_rdptr  <= '0;
         r_usedw  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wrptr <= r_wrptr + 1'b1;
         end
         if (w_rd_ok) begin
            r_rdptr <= r_rdptr + 1'b1;
         end
         r_usedw  <= w_usedw_nxt;
         r_full   <= (w_usedw_nxt == LP_DEPTH);
         r_empty  <= (w_usedw_nxt == '0);
         r_afull  <= (w_usedw_nxt >= LP_AF);
         r_aempty <= (w_usedw_nxt <= LP_AE);
         r_ovf    <= en & wrreq & r_full;
         r_udf    <= en & rdreq & r_empty;
      end
   end

   // Registered read port; unused (held at zero) in show-ahead mode
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout <= '0;
      end else if (w_rd_ok && (SHOW_AHEAD == 0)) begin
         r_dout <= r_mem[r_rdptr];
      end
   end

   generate
      if (SHOW_AHEAD != 0) begin : g_show_ahead
         // Head word is presented whenever something is stored
         assign data_out = r_empty ? r_dout : r_mem[r_rdptr];
      end else begin : g_registered
         assign data_out = r_dout;
      end
   endgenerate

   assign usedw        = r_usedw;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table vectors, corner sequences and random traffic
// against a queue model, plus a show-ahead instance.
module tb_sync_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, wrreq, rdreq;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        full, empty, almost_full, almost_empty;
   logic [4:0]  usedw;
   logic        overflow, underflow;

   logic        s_en, s_wr, s_rd;
   logic [15:0] s_din;
   logic [15:0] s_dout;
   logic        s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic [4:0]  s_usedw;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sync_fifo #(
      .DATA_WIDTH(16), .ADDR_BITS(4), .ALMOST_FULL(12),
      .ALMOST_EMPTY(2), .SHOW_AHEAD(0)
   ) u_reg (
      .clk(clk), .rst(rst), .en(en), .wrreq(wrreq), .rdreq(rdreq),
      .data_in(data_in), .data_out(data_out), .full(full),
      .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .usedw(usedw),
      .overflow(overflow), .underflow(underflow)
   );

   sync_fifo #(
      .DATA_WIDTH(16), .ADDR_BITS(4), .ALMOST_FULL(12),
      .ALMOST_EMPTY(2), .SHOW_AHEAD(1)
   ) u_sa (
      .clk(clk), .rst(rst), .en(s_en), .wrreq(s_wr), .rdreq(s_rd),
      .data_in(s_din), .data_out(s_dout), .full(s_full),
      .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .usedw(s_usedw),
      .overflow(s_ovf), .underflow(s_udf)
   );

   // reference model: contents as a queue, plus expected pulses/data
   logic [15:0] q [$];
   logic [15:0] m_dout;
   bit          m_ovf, m_udf;

   typedef struct {
      bit          en, wr, rd;
      logic [15:0] din;
      int          usedw;
      bit          full, empty, af, ae, ovf, udf;
      logic [15:0] dout;
   } vec_t;

   vec_t tv [$];

   function automatic void chk(string nm, int act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   task automatic model_update(input bit e, w, r,
                               input logic [15:0] d);
      int n;
      n = q.size();
      m_ovf = e && w && (n == 16);
      m_udf = e && r && (n == 0);
      if (e) begin
         if (r && n > 0) m_dout = q.pop_front();
         if (w && n < 16) q.push_back(d);
      end
   endtask

   task automatic model_check(string tag);
      int n;
      n = q.size();
      chk({tag, "_usedw"}, int'(usedw), n);
      chk({tag, "_full"}, int'(full), int'(n == 16));
      chk({tag, "_empty"}, int'(empty), int'(n == 0));
      chk({tag, "_afull"}, int'(almost_full), int'(n >= 12));
      chk({tag, "_aempty"}, int'(almost_empty), int'(n <= 2));
      chk({tag, "_ovf"}, int'(overflow), int'(m_ovf));
      chk({tag, "_udf"}, int'(underflow), int'(m_udf));
      chk({tag, "_dout"}, int'(data_out), int'(m_dout));
   endtask

   // inputs change at negedge; outputs compared at the next negedge
   task automatic step(input bit e, w, r, input logic [15:0] d,
                       input bit mchk, input string tag);
      en = e; wrreq = w; rdreq = r; data_in = d;
      @(posedge clk);
      model_update(e, w, r, d);
      @(negedge clk);
      if (mchk) model_check(tag);
   endtask

   task automatic do_reset(input bit w);
      rst = 1'b1; en = 1'b1; wrreq = w; rdreq = 1'b0;
      data_in = 16'hBEEF;
      @(posedge clk);
      q.delete();
      m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
      @(negedge clk);
      rst = 1'b0; wrreq = 1'b0;
   endtask

   function automatic vec_t mk(bit e, bit w, bit r, logic [15:0] d,
                               int u, bit o, bit un,
                               logic [15:0] dq);
      vec_t v;
      v.en = e; v.wr = w; v.rd = r; v.din = d; v.usedw = u;
      v.full = (u == 16); v.empty = (u == 0);
      v.af = (u >= 12); v.ae = (u <= 2);
      v.ovf = o; v.udf = un; v.dout = dq;
      return v;
   endfunction

   initial begin
      rst = 1'b1; en = 0; wrreq = 0; rdreq = 0; data_in = 0;
      s_en = 0; s_wr = 0; s_rd = 0; s_din = 0;
      m_dout = '0; m_ovf = 0; m_udf = 0;

      // fill, overflow, drain, underflow
      for (int i = 0; i < 16; i++)
         tv.push_back(mk(1, 1, 0, 16'(i + 1), i + 1, 0, 0, 16'h0));
      tv.push_back(mk(1, 1, 0, 16'hDEAD, 16, 1, 0, 16'h0));
      tv.push_back(mk(1, 0, 0, 16'h0, 16, 0, 0, 16'h0));
      for (int i = 0; i < 16; i++)
         tv.push_back(mk(1, 0, 1, 16'h0, 15 - i, 0, 0, 16'(i + 1)));
      tv.push_back(mk(1, 0, 1, 16'h0, 0, 0, 1, 16'h0010));
      tv.push_back(mk(1, 0, 0, 16'h0, 0, 0, 0, 16'h0010));

      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset(1'b0);
      model_check("reset");

      foreach (tv[i]) begin
         step(tv[i].en, tv[i].wr, tv[i].rd, tv[i].din, 0, "tv");
         chk($sformatf("tv%0d_usedw", i), int'(usedw), tv[i].usedw);
         chk($sformatf("tv%0d_full", i), int'(full), int'(tv[i].full));
         chk($sformatf("tv%0d_empty", i), int'(empty), int'(tv[i].empty));
         chk($sformatf("tv%0d_af", i), int'(almost_full), int'(tv[i].af));
         chk($sformatf("tv%0d_ae", i), int'(almost_empty), int'(tv[i].ae));
         chk($sformatf("tv%0d_ovf", i), int'(overflow), int'(tv[i].ovf));
         chk($sformatf("tv%0d_udf", i), int'(underflow), int'(tv[i].udf));
         chk($sformatf("tv%0d_dout", i), int'(data_out), int'(tv[i].dout));
      end

      // simultaneous read/write at usedw=5
      for (int i = 0; i < 5; i++) step(1, 1, 0, 16'(16'h100 + i), 1, "pre5");
      for (int i = 0; i < 20; i++)
         step(1, 1, 1, 16'($urandom), 1, "simul5");
      chk("simul5_usedw", int'(usedw), 5);

      // both requests while full
      while (q.size() < 16) step(1, 1, 0, 16'($urandom), 1, "fill");
      step(1, 1, 1, 16'h7777, 1, "bothfull");
      chk("bothfull_usedw", int'(usedw), 15);
      chk("bothfull_ovf", int'(overflow), 1);

      // both requests while empty: write wins, no bypass
      while (q.size() > 0) step(1, 0, 1, 16'h0, 1, "drain");
      step(1, 1, 1, 16'h4242, 1, "bothempty");
      chk("bothempty_usedw", int'(usedw), 1);
      chk("bothempty_udf", int'(underflow), 1);
      step(1, 0, 1, 16'h0, 1, "bothempty_rd");
      chk("bothempty_data", int'(data_out), 16'h4242);

      // wrap-around: 40 write/read pairs
      for (int i = 0; i < 40; i++) begin
         step(1, 1, 0, 16'($urandom), 1, "wrap_wr");
         step(1, 0, 1, 16'h0, 1, "wrap_rd");
      end

      // en gating at usedw=7
      for (int i = 0; i < 7; i++) step(1, 1, 0, 16'($urandom), 1, "pre7");
      for (int i = 0; i < 10; i++)
         step(0, 1'($urandom), 1'($urandom), 16'($urandom), 1, "engate");
      chk("engate_usedw", int'(usedw), 7);

      // random mixed traffic
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 7) != 0), 1'($urandom),
              1'($urandom), 16'($urandom), 1, "rand");

      // reset with a concurrent write at usedw=9
      while (q.size() < 9) step(1, 1, 0, 16'($urandom), 1, "pre9");
      while (q.size() > 9) step(1, 0, 1, 16'h0, 1, "pre9");
      step(1, 0, 1, 16'h0, 1, "pre9_rd");
      step(1, 1, 0, 16'h5151, 1, "pre9_wr");
      do_reset(1'b1);
      chk("rst_usedw", int'(usedw), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_dout", int'(data_out), 0);
      model_check("rst");
      step(1, 0, 0, 16'h0, 1, "rst_idle");

      // show-ahead instance
      chk("sa_rst_empty", int'(s_empty), 1);
      chk("sa_rst_dout", int'(s_dout), 0);
      s_en = 1; s_wr = 1; s_din = 16'hA5A5;
      @(posedge clk); #1;
      s_wr = 0;
      chk("sa_empty_fall", int'(s_empty), 0);
      chk("sa_head", int'(s_dout), 16'hA5A5);
      @(negedge clk);
      s_rd = 1;
      @(posedge clk); #1;
      s_rd = 0;
      chk("sa_consumed_empty", int'(s_empty), 1);
      chk("sa_consumed_usedw", int'(s_usedw), 0);
      @(negedge clk);
      s_wr = 1; s_din = 16'h1111;
      @(negedge clk);
      s_din = 16'h2222;
      @(negedge clk);
      s_wr = 0;
      chk("sa_two_head", int'(s_dout), 16'h1111);
      chk("sa_two_usedw", int'(s_usedw), 2);
      s_rd = 1;
      @(negedge clk);
      s_rd = 0;
      chk("sa_next_head", int'(s_dout), 16'h2222);
      chk("sa_next_usedw", int'(s_usedw), 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that replaces the fixed 16x1024 buffer with one that has correct occupancy accounting, registered full/empty and almost-full/almost-empty flags, simultaneous read/write, and protected overflow/underflow. It is the default elastic buffer between streaming datapath stages in one clock domain. Depth is a power of two. Read mode is selectable: registered-read (normal) or show-ahead.

## Interface

- DATA_WIDTH, 16, word width in bits
- ADDR_BITS, 10, log2 of depth; DEPTH = 2**ADDR_BITS
- ALMOST_FULL, 768, almost_full asserts when usedw >= this value (1..DEPTH)
- ALMOST_EMPTY, 16, almost_empty asserts when usedw <= this value (0..DEPTH-1)
- SHOW_AHEAD, 0, 0 = registered read, 1 = show-ahead (head word presented before rdreq)

- clk, input, 1, single clock; all logic on rising edge
- rst, input, 1, synchronous, active-high reset
- en, input, 1, global enable; when low, requests are ignored and state holds
- wrreq, input, 1, write request
- rdreq, input, 1, read request (read acknowledge in show-ahead mode)
- data_in, input, DATA_WIDTH, write data
- data_out, output, DATA_WIDTH, read data
- full, output, 1, usedw == DEPTH
- empty, output, 1, usedw == 0
- almost_full, output, 1, usedw >= ALMOST_FULL
- almost_empty, output, 1, usedw <= ALMOST_EMPTY
- usedw, output, ADDR_BITS+1, words stored, 0..DEPTH
- overflow, output, 1, one-cycle pulse: write rejected because full
- underflow, output, 1, one-cycle pulse: read rejected because empty

## Operation

- Write accepted (wr_ok) = en & wrreq & !full. Store data_in at wrptr; wrptr increments.
- Read accepted (rd_ok) = en & rdreq & !empty. rdptr increments.
- Pointers are ADDR_BITS wide and wrap from DEPTH-1 to 0 with no special case.
- usedw is updated as follows: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither are accepted. It never exceeds DEPTH and never goes below 0.
- Simultaneous requests:
  - When full, the write is rejected (overflow pulses) and the read is accepted. usedw becomes DEPTH-1.
  - When empty, the write is accepted and the read is rejected (underflow pulses). There is no bypass from data_in to data_out.
- Registered-read mode (SHOW_AHEAD=0): data_out <= mem[rdptr] on rd_ok. At all other times data_out holds its value.
- Show-ahead mode (SHOW_AHEAD=1): data_out = mem[rdptr] combinationally. It is valid whenever empty=0. rd_ok consumes the head word, and the next word appears after the edge.
- Flag derivation:
  - All flags are derived from the registered usedw, so they change on the same edge as usedw.
  - full and empty are computed from usedw, never from pointer equality.
- Overflow and underflow:
  - Registered pulses, high for exactly the one cycle after a rejected request.
  - They are not sticky.
  - No pulse is generated while en=0.
- en=0: pointers, memory, usedw, flags and data_out all hold.
- Reset:
  - rst has priority over every request in the same cycle.
  - The memory array is not cleared.

## Timing

- Reset values (the cycle after rst sampled high): usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, pointers=0, data_out=0.
- Write to flag latency: a write on edge N gives updated usedw, empty=0, full and almost flags after edge N.
- Write to read availability: the earliest read of that word is accepted at edge N+1.
- Registered-mode read latency: rdreq sampled at edge N gives data_out valid after edge N (one clock).
- Show-ahead: the first word is visible on data_out in the same cycle empty falls.
- Reset mid-operation: the FIFO reads empty from the next cycle. A write issued in the reset cycle is discarded.
- Throughput: one write and one read per cycle, sustained, when neither full nor empty.

## Test plan

All scenarios use DATA_WIDTH=16, ADDR_BITS=4 (DEPTH=16), ALMOST_FULL=12, ALMOST_EMPTY=2.

- **Fill and drain:** write 0x0001..0x0010 (16 words), then read 16 words.
  - full=1 and usedw=16 after the 16th write. almost_full rises after the 12th write.
  - Reads return 0x0001..0x0010 in order, one cycle after each rdreq.
  - empty=1 and usedw=0 at the end. almost_empty rises when usedw reaches 2.
- **Overflow/underflow:** write a 17th word while full, then read while empty.
  - Each produces a single one-cycle pulse on overflow or underflow, respectively.
  - usedw stays 16 (resp. 0), and the stored data is unchanged.
- **Simultaneous access:**
  - At usedw=5, wrreq+rdreq for 20 cycles: usedw stays 5 and the data order is preserved.
  - At full, both requests: read accepted, overflow pulses, usedw becomes 15.
  - At empty, both requests: underflow pulses, usedw becomes 1.
- **Wrap-around:** perform 40 interleaved write/read pairs with random data. The scoreboard matches every word, confirming the pointers wrap past 15 to 0 correctly.
- **en gating and reset:**
  - With en=0, 10 cycles of wrreq/rdreq produce no change in usedw, data_out or flags, and no pulses.
  - rst asserted at usedw=9 together with wrreq: next cycle usedw=0, empty=1, data_out=0.
- **Show-ahead (SHOW_AHEAD=1):** write 0xA5A5.
  - data_out=0xA5A5 in the cycle empty falls, with no rdreq needed.
  - rdreq then consumes it and empty returns to 1.
